// File: rtl/usb4_pulse_pkg.sv
// Shared definitions for the multi-channel pulse generator:
// mode encodings and the pulse-counter width helper.
package usb4_pulse_pkg;

    typedef enum logic [1:0] {
        MODE_RISE  = 2'b00,
        MODE_FALL  = 2'b01,
        MODE_BOTH  = 2'b10,
        MODE_LEVEL = 2'b11
    } mode_e;

    // Bits needed to hold a down-counter that starts at pulse_w.
    function automatic int cnt_width(input int pulse_w);
        return $clog2(pulse_w + 1);
    endfunction

endpackage

// File: rtl/pulse_chan.sv
// One pulse-generator channel: edge detect, stretch counter,
// sticky pending and overflow flags.
module pulse_chan
    import usb4_pulse_pkg::*;
#(
    parameter int PULSE_W = 1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       en,
    input  logic [1:0] mode,
    input  logic       lvl_sig,
    input  logic       pend_ack,
    output logic       pulse_sig,
    output logic       pend,
    output logic       ovf
);

    localparam int CNT_W = cnt_width(PULSE_W);

    logic             prev_q;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             pulse_q, pulse_d;
    logic             pend_q, pend_d;
    logic             ovf_q, ovf_d;
    logic             rise, fall, edge_hit, evt, ack_eff;
    logic             is_level;

    // Edge selection, counter next state and flag next state.
    always_comb begin
        rise     = lvl_sig & ~prev_q;
        fall     = ~lvl_sig & prev_q;
        edge_hit = 1'b0;
        is_level = 1'b0;
        case (mode)
            MODE_RISE:  edge_hit = rise;
            MODE_FALL:  edge_hit = fall;
            MODE_BOTH:  edge_hit = rise | fall;
            MODE_LEVEL: is_level = 1'b1;
            default:    edge_hit = 1'b0;
        endcase
        evt     = en & edge_hit;
        // An ack on an idle channel must not disturb anything.
        ack_eff = pend_ack & pend_q;

        cnt_d = cnt_q;
        if (!en || is_level) begin
            cnt_d = '0;
        end else if (evt) begin
            // Retrigger simply reloads, so overlapping events merge.
            cnt_d = CNT_W'(PULSE_W);
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - CNT_W'(1);
        end

        pulse_d = is_level ? (en & lvl_sig) : (cnt_d != '0);

        pend_d = pend_q;
        ovf_d  = ovf_q;
        if (evt) begin
            pend_d = 1'b1;
        end else if (ack_eff) begin
            pend_d = 1'b0;
        end
        // Ack wins over a simultaneous event for the overflow flag.
        if (ack_eff) begin
            ovf_d = 1'b0;
        end else if (evt && pend_q) begin
            ovf_d = 1'b1;
        end
    end

    // Channel state registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            prev_q  <= 1'b0;
            cnt_q   <= '0;
            pulse_q <= 1'b0;
            pend_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            prev_q  <= lvl_sig;
            cnt_q   <= cnt_d;
            pulse_q <= pulse_d;
            pend_q  <= pend_d;
            ovf_q   <= ovf_d;
        end
    end

    assign pulse_sig = pulse_q;
    assign pend      = pend_q;
    assign ovf       = ovf_q;

endmodule

// File: rtl/multi_pulse_gen.sv
// Multi-channel pulse generator: NUM_CH independent pulse_chan
// instances plus a combined activity flag.
module multi_pulse_gen
    import usb4_pulse_pkg::*;
#(
    parameter int NUM_CH  = 4,
    parameter int PULSE_W = 1
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [NUM_CH-1:0]   en,
    input  logic [2*NUM_CH-1:0] mode,
    input  logic [NUM_CH-1:0]   lvl_sig,
    input  logic [NUM_CH-1:0]   pend_ack,
    output logic [NUM_CH-1:0]   pulse_sig,
    output logic [NUM_CH-1:0]   pend,
    output logic [NUM_CH-1:0]   ovf,
    output logic                any_pulse
);

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        pulse_chan #(
            .PULSE_W (PULSE_W)
        ) u_chan (
            .clk       (clk),
            .reset     (reset),
            .en        (en[i]),
            .mode      (mode[2*i +: 2]),
            .lvl_sig   (lvl_sig[i]),
            .pend_ack  (pend_ack[i]),
            .pulse_sig (pulse_sig[i]),
            .pend      (pend[i]),
            .ovf       (ovf[i])
        );
    end

    // Activity flag straight off the registered pulse bits.
    always_comb begin
        any_pulse = |pulse_sig;
    end

endmodule

// File: tb/tb_multi_pulse_gen.sv
// Directed bench for multi_pulse_gen; three instances with PULSE_W 1, 3, 4
// share one stimulus stream.
module tb_multi_pulse_gen;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] en, lvl, ack;
    logic [7:0] mode;

    logic [3:0] p1_pulse, p1_pend, p1_ovf;
    logic [3:0] p3_pulse, p3_pend, p3_ovf;
    logic [3:0] p4_pulse, p4_pend, p4_ovf;
    logic       p1_any, p3_any, p4_any;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    multi_pulse_gen #(.NUM_CH(4), .PULSE_W(1)) dut_w1 (
        .clk(clk), .reset(reset), .en(en), .mode(mode), .lvl_sig(lvl),
        .pend_ack(ack), .pulse_sig(p1_pulse), .pend(p1_pend), .ovf(p1_ovf),
        .any_pulse(p1_any));

    multi_pulse_gen #(.NUM_CH(4), .PULSE_W(3)) dut_w3 (
        .clk(clk), .reset(reset), .en(en), .mode(mode), .lvl_sig(lvl),
        .pend_ack(ack), .pulse_sig(p3_pulse), .pend(p3_pend), .ovf(p3_ovf),
        .any_pulse(p3_any));

    multi_pulse_gen #(.NUM_CH(4), .PULSE_W(4)) dut_w4 (
        .clk(clk), .reset(reset), .en(en), .mode(mode), .lvl_sig(lvl),
        .pend_ack(ack), .pulse_sig(p4_pulse), .pend(p4_pend), .ovf(p4_ovf),
        .any_pulse(p4_any));

    task automatic check(input string tag, input logic [3:0] got, input logic [3:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %b expected %b", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b1; en = '0; mode = '0; lvl = '0; ack = '0;
        step(); step();
        check("rst_pulse", p1_pulse, 4'b0000);
        check("rst_pend",  p1_pend,  4'b0000);
        check("rst_ovf",   p1_ovf,   4'b0000);
        check("rst_any",   4'(p1_any), 4'b0000);
        check("rst_p4",    p4_pulse | p4_pend | p4_ovf, 4'b0000);
        reset = 1'b0;
        step();

        // Single rise, PULSE_W=1: one-cycle pulse one edge after the rise.
        en = 4'b0001; lvl = 4'b0001;
        step();
        check("w1_pulse_on",  p1_pulse, 4'b0001);
        check("w1_any_on",    4'(p1_any), 4'b0001);
        check("w1_pend",      p1_pend,  4'b0001);
        step();
        check("w1_pulse_off", p1_pulse, 4'b0000);
        check("w1_any_off",   4'(p1_any), 4'b0000);
        step(); step(); step();
        check("w1_held_off",  p1_pulse, 4'b0000);
        check("w1_pend_held", p1_pend,  4'b0001);
        ack = 4'b0001; lvl = 4'b0000;
        step();
        check("w1_ack_clr",   p1_pend,  4'b0000);
        ack = 4'b0000;

        // Both-edge mode, PULSE_W=3, retrigger two cycles later.
        en = 4'b0010; mode = 8'h08;
        step();
        check("both_mode_chg", p3_pulse, 4'b0000);
        lvl = 4'b0010;
        step();
        check("both_c1", p3_pulse, 4'b0010);
        step();
        check("both_c2", p3_pulse, 4'b0010);
        lvl = 4'b0000;
        step();
        check("both_c3", p3_pulse, 4'b0010);
        step();
        check("both_c4", p3_pulse, 4'b0010);
        step();
        check("both_c5", p3_pulse, 4'b0010);
        check("both_any5", 4'(p3_any), 4'b0001);
        step();
        check("both_c6", p3_pulse, 4'b0000);
        check("both_any6", 4'(p3_any), 4'b0000);
        check("both_ovf", p3_ovf, 4'b0010);
        ack = 4'b0010;
        step();
        check("both_ack", p3_pend | p3_ovf, 4'b0000);
        ack = 4'b0000;

        // Pending / overflow handling on ch2.
        en = 4'b0100; mode = 8'h00;
        lvl = 4'b0100;
        step();
        check("ov_pend1", p1_pend, 4'b0100);
        check("ov_ovf0",  p1_ovf,  4'b0000);
        lvl = 4'b0000;
        step();
        lvl = 4'b0100;
        step();
        check("ov_ovf1",  p1_ovf,  4'b0100);
        check("ov_pend2", p1_pend, 4'b0100);
        lvl = 4'b0000; ack = 4'b0100;
        step();
        check("ov_ack_pend", p1_pend, 4'b0000);
        check("ov_ack_ovf",  p1_ovf,  4'b0000);
        ack = 4'b0000; lvl = 4'b0100;
        step();
        lvl = 4'b0000;
        step();
        lvl = 4'b0100; ack = 4'b0100;
        step();
        check("ov_evtack_pend", p1_pend, 4'b0100);
        check("ov_evtack_ovf",  p1_ovf,  4'b0000);
        lvl = 4'b0000;
        step();
        check("ov_final_pend", p1_pend, 4'b0000);
        ack = 4'b0000;

        // Level mode on ch3.
        en = 4'b1000; mode = 8'hC0; lvl = 4'b1000;
        step();
        check("lvl_c1", p1_pulse, 4'b1000);
        step(); step(); step();
        check("lvl_c4", p1_pulse, 4'b1000);
        lvl = 4'b0000;
        step();
        check("lvl_off", p1_pulse, 4'b0000);
        check("lvl_nopend", p1_pend, 4'b0000);
        lvl = 4'b1000;
        step();
        check("lvl_on2", p3_pulse, 4'b1000);
        en = 4'b0000;
        step();
        check("lvl_en_off", p3_pulse, 4'b0000);
        lvl = 4'b0000;
        step();

        // Enable drop mid-pulse in edge mode, PULSE_W=4.
        en = 4'b0001; mode = 8'h00; lvl = 4'b0001;
        step();
        check("en_pulse_on", p4_pulse, 4'b0001);
        en = 4'b0000;
        step();
        check("en_pulse_off", p4_pulse, 4'b0000);
        check("en_pend_kept", p4_pend, 4'b0001);
        ack = 4'b1111; lvl = 4'b0000;
        step();
        ack = 4'b0000;

        // Reset mid-pulse with the level held high across release.
        en = 4'b0001; lvl = 4'b0001;
        step();
        check("rm_c1", p4_pulse, 4'b0001);
        step();
        check("rm_c2", p4_pulse, 4'b0001);
        reset = 1'b1;
        step();
        check("rm_rst_pulse", p4_pulse, 4'b0000);
        check("rm_rst_flags", p4_pend | p4_ovf, 4'b0000);
        check("rm_rst_any",   4'(p4_any), 4'b0000);
        step();
        reset = 1'b0;
        step();
        check("rm_rel_pulse", p4_pulse, 4'b0001);
        check("rm_rel_pend",  p4_pend,  4'b0001);
        step(); step(); step();
        check("rm_r4", p4_pulse, 4'b0001);
        step();
        check("rm_r5", p4_pulse, 4'b0000);
        check("rm_single_evt", p4_ovf, 4'b0000);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/multi_pulse_gen.md
MULTI_PULSE_GEN -- requirements
Module: multi_pulse_gen

Interface
REQ-001 Parameter NUM_CH, default 4: number of independent channels, legal 1..16.
REQ-002 Parameter PULSE_W, default 1: output pulse length in clk cycles, legal 1..16.
REQ-003 clk  in  1  sole clock; all state updates on rising edge.
REQ-004 reset  in  1  synchronous, active-high reset.
REQ-005 en  in  NUM_CH  per-channel enable.
REQ-006 mode  in  2*NUM_CH  per-channel mode, bits [2i+1:2i]: 00 rise, 01 fall, 10 both edges, 11 level.
REQ-007 lvl_sig  in  NUM_CH  synchronous level inputs (s_read, s_write, trans_error, t_valid class signals).
REQ-008 pend_ack  in  NUM_CH  per-channel acknowledge of pending event.
REQ-009 pulse_sig  out  NUM_CH  stretched pulse outputs.
REQ-010 pend  out  NUM_CH  sticky event-pending flags.
REQ-011 ovf  out  NUM_CH  sticky overflow flags (event lost while pending).
REQ-012 any_pulse  out  1  OR-reduction of pulse_sig.

Function
REQ-013 Each channel SHALL register lvl_sig into prev every cycle, regardless of en or mode.
REQ-014 rise = lvl_sig & ~prev; fall = ~lvl_sig & prev; event = en & (mode-selected edge); mode 10 uses rise|fall.
REQ-015 On event at edge k, a down-counter SHALL load PULSE_W; pulse_sig = (counter != 0), registered, so pulse_sig is high for cycles k+1..k+PULSE_W (latency 1 cycle).
REQ-016 Event while counter nonzero SHALL reload PULSE_W (retrigger extends pulse; no gap, no double count).
REQ-017 Mode 11: pulse_sig SHALL equal lvl_sig registered once (1-cycle delay), gated by en; counter unused; no pend/ovf updates.
REQ-018 en low SHALL clear the counter at next edge (pulse_sig low from following cycle); pend/ovf unaffected.
REQ-019 A mode change SHALL NOT itself generate an event; new mode applies from the next cycle's comparison.
REQ-020 pend SHALL set on event; clear on pend_ack with no same-cycle event; event and pend_ack in same cycle -> pend stays 1.
REQ-021 ovf SHALL set on event when pend=1 and pend_ack=0; clear on pend_ack (same-cycle event+ack while pend=1 -> ovf stays 0).
REQ-022 pend_ack on a channel with pend=0 SHALL have no effect.
REQ-023 any_pulse SHALL be combinational OR of registered pulse_sig bits (no extra latency).
REQ-024 Channels SHALL be fully independent; no cross-channel arbitration.

Reset
REQ-025 reset high at a clk edge SHALL clear prev, counter, pulse_sig, pend, ovf to 0; any_pulse 0.
REQ-026 Since prev resets to 0, lvl_sig high in the first post-reset cycle SHALL produce a rising event (mode 00/10, en=1).
REQ-027 reset asserted mid-pulse SHALL terminate pulse immediately (pulse_sig 0 the cycle after the reset edge).

Structure
REQ-028 Package usb4_pulse_pkg SHALL hold mode encodings (MODE_RISE, MODE_FALL, MODE_BOTH, MODE_LEVEL) and PULSE_W counter-width function.
REQ-029 Counter width SHALL be $clog2(PULSE_W+1) bits.
REQ-030 One sub-module pulse_chan (single channel: prev, counter, pend, ovf) SHALL be instantiated NUM_CH times via generate.

Verification
REQ-031 NUM_CH=4, PULSE_W=1, mode 00: ch0 lvl_sig 0->1 held 5 cycles -> pulse_sig[0] high exactly 1 cycle, 1 cycle after rise; pend[0]=1.
REQ-032 PULSE_W=3, mode 10: toggle ch1 at cycles 0 and 2 -> pulse_sig[1] high cycles 1..5 contiguous (retrigger), any_pulse mirrors it.
REQ-033 ch2 mode 00, two rises with no ack -> ovf[2]=1; pend_ack[2] pulse -> pend[2]=0, ovf[2]=0; event+ack same cycle -> pend=1, ovf=0.
REQ-034 ch3 mode 11, lvl_sig 1 for 4 cycles, en=1 -> pulse_sig[3] high 4 cycles delayed 1; en=0 mid-way -> low next cycle.
REQ-035 PULSE_W=4, reset asserted 2 cycles into pulse -> all outputs 0 next cycle; lvl_sig held high through reset release -> one rising event after release.
